// File: rtl/pwm_capture_pkg.sv
// Shared types and default constants for the PWM capture block.
// Optional glitch filter is selected with the PWM_CAPTURE_FILTER_EN macro.
package pwm_capture_pkg;

    // Measurement state: waiting for a first rising edge, or timing a period.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 100000000;

endpackage

// File: rtl/sync_edge_detect.sv
// Input conditioning for pwm_capture: synchronizer chain, optional glitch
// filter (enabled when PWM_CAPTURE_FILTER_EN is defined), and edge strobes
// derived from the conditioned level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] filt_cnt;
    logic          filt_q;

    // Accept a new level only after it has persisted for FILTER_LEN cycles;
    // any reversion to the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_q   <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == CW'(FILTER_LEN - 1)) begin
            filt_q   <= sync_q[SYNC_STAGES-1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign s = filt_q;
`else
    assign s = sync_q[SYNC_STAGES-1];
`endif

    // One-cycle delayed copy of the conditioned level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign level = s;
    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time of sig_in in clk
// cycles, strobes valid on each completed period, flags a stall when no rise
// arrives within TIMEOUT cycles. Optional input glitch filter is selected with
// the PWM_CAPTURE_FILTER_EN macro.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             stalled,
    output logic             level
);

    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] per_cnt;
    logic [WIDTH-1:0] hi_cnt;
    logic [WIDTH-1:0] hi_lat;
    logic             s;
    logic             rise;
    logic             fall;
    logic             timeout_hit;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .level  (s),
        .rise   (rise),
        .fall   (fall)
    );

    assign level       = s;
    assign timeout_hit = (state == ARMED) && (per_cnt == TIMEOUT_W);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: arm on a rise, drop back on timeout (a rise takes priority)
    // or whenever capture is disabled.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && rise) state_next = ARMED;
            ARMED:   if (!rise && timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!en) state_next = IDLE;
    end

    // Counters and output registers; outputs hold while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            hi_lat    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
        end else if (!en) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            hi_lat  <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        period    <= per_cnt;
                        high_time <= hi_lat;
                        valid     <= 1'b1;
                        stalled   <= 1'b0;
                        per_cnt   <= CNT_ONE;
                        hi_cnt    <= CNT_ONE;
                    end else if (timeout_hit) begin
                        stalled   <= 1'b1;
                        period    <= '0;
                        high_time <= '0;
                        per_cnt   <= '0;
                        hi_cnt    <= '0;
                        hi_lat    <= '0;
                    end else begin
                        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;
                        if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
                        if (fall) hi_lat <= hi_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed waveforms checked against a timestamp
// model of the conditioned input, plus literal expectations after each phase.
// Builds with or without PWM_CAPTURE_FILTER_EN.
module tb_pwm_capture;

    localparam int WIDTH = 16;
    localparam int SYNC  = 2;
    localparam int TMO   = 100;
    localparam int FL    = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int MIN_PULSE = FL;
`else
    localparam int MIN_PULSE = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             stalled;
    logic             level;

    // Clock.
    always #5 clk = ~clk;

    pwm_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TMO),
        .FILTER_LEN  (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stalled   (stalled),
        .level     (level)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcount   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: sig_in history, conditioned level, and timestamps of edges.
    bit          sig_hist [0:16383];
    int          first_ok = 0;
    bit          m_armed  = 0;
    int          last_rise = 0;
    int          last_fall = 0;
    logic [63:0] exp_period = 0;
    logic [63:0] exp_high   = 0;
    bit          exp_valid  = 0;
    bit          exp_stalled = 0;
    bit          s_prev = 0;
    bit          s_filt = 0;
    bit          s_c;
    bit          m_rise;
    bit          m_fall;
    bit          all_diff;

    // Synchronizer output in cycle c is sig_in of cycle c-SYNC, zero if that
    // sample predates the end of the last reset.
    function automatic bit raw_at(input int c);
        if (c - SYNC < 0 || c - SYNC < first_ok) return 1'b0;
        return sig_hist[c - SYNC];
    endfunction

    // Compare process: checks every output each cycle, then advances the model.
    always @(negedge clk) begin
        if (cyc < 16384) sig_hist[cyc] = sig_in;
        if (!rst_n) begin
            exp_period = 0; exp_high = 0; exp_valid = 0; exp_stalled = 0;
            m_armed = 0; s_prev = 0; s_filt = 0; first_ok = cyc + 1;
            s_c = 0;
        end else begin
`ifdef PWM_CAPTURE_FILTER_EN
            s_c = s_filt;
`else
            s_c = raw_at(cyc);
`endif
        end
        check("level", level, s_c);
        check("period", period, exp_period);
        check("high_time", high_time, exp_high);
        check("valid", valid, exp_valid);
        check("stalled", stalled, exp_stalled);
        if (valid === 1'b1) vcount++;
        if (rst_n) begin
            m_rise = s_c & ~s_prev;
            m_fall = ~s_c & s_prev;
            exp_valid = 0;
            if (!en) begin
                m_armed = 0;
            end else if (!m_armed) begin
                if (m_rise) begin m_armed = 1; last_rise = cyc; end
            end else if (m_rise) begin
                exp_period  = cyc - last_rise;
                exp_high    = last_fall - last_rise;
                exp_valid   = 1;
                exp_stalled = 0;
                last_rise   = cyc;
            end else if (cyc - last_rise == TMO) begin
                exp_stalled = 1; exp_period = 0; exp_high = 0; m_armed = 0;
            end else if (m_fall) begin
                last_fall = cyc;
            end
            s_prev = s_c;
`ifdef PWM_CAPTURE_FILTER_EN
            all_diff = 1;
            for (int k = 0; k < FL; k++) if (raw_at(cyc - k) == s_filt) all_diff = 0;
            if (all_diff) s_filt = ~s_filt;
`endif
        end
        cyc++;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic drive(input bit v, input int n);
        repeat (n) begin
            sig_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    int v0;

    initial begin
        rst_n = 1'b0; en = 1'b0; sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_stalled", stalled, 0);
        check("rst_level", level, 0);
        rst_n = 1'b1; en = 1'b1;
        drive(1'b0, 5);

        // 10 high / 30 low square wave.
        v0 = vcount;
        wave(10, 30, 4);
        check("sq_valid_cnt", vcount - v0, 3);
        check("sq_period", period, 40);
        check("sq_high", high_time, 10);

        // Duty sweep at a fixed 40-cycle period.
        for (int h = MIN_PULSE; h <= 40 - MIN_PULSE; h++) begin
            drive(1'b1, h);
            drive(1'b0, 40 - h);
            check("sweep_period", period, 40);
            check("sweep_high", high_time, (h == MIN_PULSE) ? 10 : h - 1);
        end
        drive(1'b1, 10);
        check("sweep_last_high", high_time, 40 - MIN_PULSE);
        check("sweep_last_period", period, 40);

        // Held high after that rise: stall at TIMEOUT.
        drive(1'b1, 110);
        check("tmo_stalled", stalled, 1);
        check("tmo_period", period, 0);
        check("tmo_high", high_time, 0);
        drive(1'b0, 10);
        wave(10, 10, 1);
        check("tmo_stall_hold", stalled, 1);
        wave(10, 10, 1);
        check("tmo_clear", stalled, 0);
        check("tmo_new_period", period, 20);
        check("tmo_new_high", high_time, 10);

        // Capture disabled mid-period, then re-enabled.
        wave(10, 10, 2);
        drive(1'b1, 8);
        en = 1'b0;
        v0 = vcount;
        drive(1'b1, 2);
        drive(1'b0, 10);
        wave(10, 10, 3);
        check("dis_no_valid", vcount - v0, 0);
        check("dis_period_hold", period, 20);
        check("dis_high_hold", high_time, 10);
        en = 1'b1;
        v0 = vcount;
        wave(10, 10, 1);
        check("reen_first_rise", vcount - v0, 0);
        wave(10, 10, 1);
        check("reen_second_rise", vcount - v0, 1);

        // Rises exactly TIMEOUT apart: the rise wins over the timeout.
        wave(10, 90, 2);
        drive(1'b1, 10);
        check("edge_tmo_period", period, 100);
        check("edge_tmo_high", high_time, 10);
        check("edge_tmo_stalled", stalled, 0);

        // Reset in the middle of a measured high phase.
        wave(10, 10, 2);
        drive(1'b1, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_period", period, 0);
        check("midrst_high", high_time, 0);
        check("midrst_valid", valid, 0);
        check("midrst_stalled", stalled, 0);
        drive(1'b0, 5);
        rst_n = 1'b1;
        v0 = vcount;
        wave(10, 10, 1);
        check("midrst_first_rise", vcount - v0, 0);
        wave(10, 10, 1);
        check("midrst_second_rise", vcount - v0, 1);
        check("midrst_period_new", period, 20);

`ifdef PWM_CAPTURE_FILTER_EN
        // 50-cycle 50% wave with 2-cycle glitches inside each phase.
        repeat (4) begin
            drive(1'b1, 10); drive(1'b0, 2); drive(1'b1, 13);
            drive(1'b0, 10); drive(1'b1, 2); drive(1'b0, 13);
        end
        drive(1'b1, 10);
        check("glitch_period", period, 50);
        check("glitch_high", high_time, 25);
`endif

        drive(1'b0, 5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
